// File: rtl/db15_joy_tx_if.sv
// db15_joy_tx_if -- three-wire DB15 serial joystick link.
//   joy_load_n : receiver -> device, low = parallel load, high = shift enabled
//   joy_clk    : receiver -> device, rising edge shifts the next bit out
//   joy_data   : device -> receiver, serial data, idles high
// master = receiver side (joy_db15), slave = device side (db15_joy_tx).
interface db15_joy_tx_if;
  logic joy_load_n;
  logic joy_clk;
  logic joy_data;

  modport master (output joy_load_n, output joy_clk, input joy_data);
  modport slave  (input joy_load_n, input joy_clk, output joy_data);
endinterface

// File: rtl/db15_joy_tx.sv
// db15_joy_tx -- device-side DB15 joystick transmitter.
// Emulates the 74x165 parallel-in/serial-out chain of the SNAC DB15 adapter:
// while joy_load_n is low the chain is transparently loaded with the
// active-low button state, and each rising joy_clk afterwards shifts the next
// bit onto joy_data. Frame = P1 bits 0..11 then P2 bits 0..11.
// Ports:
//   clk_sys     system clock (53.6 MHz)
//   reset       synchronous, active-high
//   joy         db15_joy_tx_if.slave (joy_load_n, joy_clk in; joy_data out)
//   joystick1   P1 buttons, active-high
//   joystick2   P2 buttons, active-high
//   bit_cnt     shifts taken since last load, saturates at FRAME_BITS
//   busy        high while 0 < bit_cnt < FRAME_BITS
//   frame_done  one-cycle pulse when the last bit of a frame is shifted
module db15_joy_tx #(
  parameter int SYNC_STAGES     = 2,
  parameter int FILTER_CYCLES   = 2,
  parameter int BITS_PER_PLAYER = 12,
  parameter int FRAME_BITS      = 2 * BITS_PER_PLAYER
) (
  input  logic                                clk_sys,
  input  logic                                reset,
  db15_joy_tx_if.slave                        joy,
  input  logic [BITS_PER_PLAYER-1:0]          joystick1,
  input  logic [BITS_PER_PLAYER-1:0]          joystick2,
  output logic [$clog2(FRAME_BITS+1)-1:0]     bit_cnt,
  output logic                                busy,
  output logic                                frame_done
);

  localparam int CNT_W = $clog2(FRAME_BITS + 1);
  localparam int FW    = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_BITS - 1);
  localparam logic [FW-1:0]    FLT_LAST = FW'(FILTER_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT
  } state_t;

  state_t                  state;
  logic [FRAME_BITS-1:0]   shreg;
  logic [SYNC_STAGES-1:0]  load_sync_p0;
  logic [SYNC_STAGES-1:0]  clk_sync_p0;
  logic [1:0]              raw_p1;   // [0] load_n, [1] clk
  logic [1:0]              filt_p2;
  logic [1:0]              filt_d_p2;
  logic                    load_n_f;
  logic                    clk_rise;

  // ---- stage p0: metastability synchronizers, idle high ----
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      load_sync_p0 <= '1;
      clk_sync_p0  <= '1;
    end else begin
      load_sync_p0 <= {load_sync_p0[SYNC_STAGES-2:0], joy.joy_load_n};
      clk_sync_p0  <= {clk_sync_p0[SYNC_STAGES-2:0], joy.joy_clk};
    end
  end

  assign raw_p1 = {clk_sync_p0[SYNC_STAGES-1], load_sync_p0[SYNC_STAGES-1]};

  // ---- stage p1 -> p2: glitch filter ----
  // The filtered level follows the synchronized level only after it has
  // disagreed for FILTER_CYCLES consecutive samples; any agreeing sample
  // restarts the count, so short glitches never reach the FSM.
  for (genvar g = 0; g < 2; g++) begin : g_filt
    logic          f;
    logic [FW-1:0] cnt;

    always_ff @(posedge clk_sys) begin
      if (reset) begin
        f   <= 1'b1;
        cnt <= '0;
      end else if (raw_p1[g] == f) begin
        cnt <= '0;
      end else if (cnt == FLT_LAST) begin
        f   <= raw_p1[g];
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end

    assign filt_p2[g] = f;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) filt_d_p2 <= '1;
    else       filt_d_p2 <= filt_p2;
  end

  assign load_n_f = filt_p2[0];
  // A clock already high when load releases produces no edge here because
  // filt_d_p2 tracks the level throughout LOAD.
  assign clk_rise = filt_p2[1] & ~filt_d_p2[1];

  // ---- stage p2 -> out: shift-register FSM ----
  // Load has priority over everything: a simultaneous clock edge is dropped
  // and a load mid-frame restarts the frame without a frame_done.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state      <= ST_IDLE;
      shreg      <= '1;
      bit_cnt    <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (!load_n_f) begin
        state   <= ST_LOAD;
        shreg   <= {~joystick2, ~joystick1};
        bit_cnt <= '0;
        busy    <= 1'b0;
      end else begin
        case (state)
          ST_LOAD: state <= ST_SHIFT;
          ST_SHIFT: begin
            if (clk_rise) begin
              // ones fill from the top so the line idles high after the frame
              shreg   <= {1'b1, shreg[FRAME_BITS-1:1]};
              bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt == CNT_LAST) begin
                busy       <= 1'b0;
                frame_done <= 1'b1;
                state      <= ST_IDLE;
              end else begin
                busy <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  // shreg[0] is the chain's serial output: ~joystick1[0] while loading,
  // frame bit k after k shifts, and all ones after reset or a full frame.
  assign joy.joy_data = shreg[0];

endmodule

// File: tb/tb_db15_joy_tx.sv
module tb_db15_joy_tx;
  localparam int SYNC_STAGES   = 2;
  localparam int FILTER_CYCLES = 2;
  localparam int LAT           = SYNC_STAGES + FILTER_CYCLES + 1;
  localparam int HOLD          = 3;
  localparam int NBITS         = 24;

  logic        clk_sys = 1'b0;
  logic        reset   = 1'b1;
  logic [11:0] j1      = 12'h000;
  logic [11:0] j2      = 12'h000;
  logic [4:0]  bit_cnt;
  logic        busy;
  logic        frame_done;

  db15_joy_tx_if jif();

  db15_joy_tx #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILTER_CYCLES(FILTER_CYCLES),
    .BITS_PER_PLAYER(12),
    .FRAME_BITS(24)
  ) dut (
    .clk_sys(clk_sys),
    .reset(reset),
    .joy(jif),
    .joystick1(j1),
    .joystick2(j2),
    .bit_cnt(bit_cnt),
    .busy(busy),
    .frame_done(frame_done)
  );

  always #9 clk_sys = ~clk_sys;

  // Model state: frame-level view of the transmitter.
  logic        loading = 1'b0;
  logic        started = 1'b0;
  int          k       = 0;
  logic [23:0] frame   = '1;
  logic        exp_fd  = 1'b0;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          t_pin   = 0;
  int          t_chg   = 0;
  int          done_cnt = 0;
  logic        chk_en  = 1'b0;
  logic        last_data = 1'b1;
  logic [23:0] cap;

  always @(posedge clk_sys) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic exp_data();
    if (loading) return ~j1[0];
    if (started && k < NBITS) return frame[k];
    return 1'b1;
  endfunction

  function automatic logic [31:0] exp_cnt();
    return loading ? 32'd0 : 32'(k);
  endfunction

  function automatic logic exp_busy();
    return !loading && k > 0 && k < NBITS;
  endfunction

  // Per-cycle compare against the model.
  always @(negedge clk_sys) begin
    if (chk_en) begin
      chk("joy_data", {31'd0, jif.joy_data}, {31'd0, exp_data()});
      chk("bit_cnt", {27'd0, bit_cnt}, exp_cnt());
      chk("busy", {31'd0, busy}, {31'd0, exp_busy()});
      chk("frame_done", {31'd0, frame_done}, {31'd0, exp_fd});
      if (frame_done === 1'b1) done_cnt++;
      if (jif.joy_data !== last_data) t_chg = cyc;
      last_data = jif.joy_data;
    end
  end

  // Change the pins, then apply the frame-level effect LAT clocks later.
  task automatic drive(input logic nl, input logic nc);
    logic oc;
    @(posedge clk_sys); #1;
    oc = jif.joy_clk;
    jif.joy_load_n = nl;
    jif.joy_clk    = nc;
    t_pin = cyc;
    repeat (LAT) @(posedge clk_sys);
    #1;
    if (!nl) begin
      loading = 1'b1;
      started = 1'b1;
      k = 0;
    end else if (loading) begin
      loading = 1'b0;
      frame = {~j2, ~j1};
    end else if (nc && !oc && started && k < NBITS) begin
      k++;
      if (k == NBITS) exp_fd = 1'b1;
    end
    @(posedge clk_sys); #1;
    exp_fd = 1'b0;
    repeat (HOLD) @(posedge clk_sys);
  endtask

  // Clock pulse of w cycles at the pin; shorter than the filter -> ignored.
  task automatic clk_pulse(input int w);
    @(posedge clk_sys); #1;
    jif.joy_clk = 1'b1;
    t_pin = cyc;
    repeat (w) @(posedge clk_sys);
    #1;
    jif.joy_clk = 1'b0;
    if (w >= FILTER_CYCLES) begin
      repeat (LAT - w) @(posedge clk_sys);
      #1;
      if (started && !loading && k < NBITS) begin
        k++;
        if (k == NBITS) exp_fd = 1'b1;
      end
    end
    @(posedge clk_sys); #1;
    exp_fd = 1'b0;
    repeat (LAT + HOLD) @(posedge clk_sys);
  endtask

  task automatic do_reset();
    @(posedge clk_sys); #1;
    reset = 1'b1;
    @(posedge clk_sys); #1;
    loading = 1'b0;
    started = 1'b0;
    k = 0;
    exp_fd = 1'b0;
    reset = 1'b0;
    repeat (LAT + HOLD) @(posedge clk_sys);
  endtask

  task automatic load_frame();
    drive(1'b0, 1'b0);
    drive(1'b1, 1'b0);
    cap = '1;
    cap[0] = jif.joy_data;
  endtask

  task automatic edges(input int from, input int to);
    for (int e = from; e <= to; e++) begin
      drive(1'b1, 1'b1);
      if (e < NBITS) cap[e] = jif.joy_data;
      drive(1'b1, 1'b0);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    jif.joy_load_n = 1'b1;
    jif.joy_clk    = 1'b0;
    repeat (3) @(posedge clk_sys);
    #1;
    reset  = 1'b0;
    chk_en = 1'b1;

    // 1: idle after reset
    chk("rst_data", {31'd0, jif.joy_data}, 32'd1);
    chk("rst_cnt", {27'd0, bit_cnt}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    repeat (1000) @(posedge clk_sys);
    #1;
    chk("idle_done", done_cnt, 0);
    chk("idle_data", {31'd0, jif.joy_data}, 32'd1);

    // 2: R+A on P1, Start on P2
    j1 = 12'h011;
    j2 = 12'h400;
    load_frame();
    chk("t2_bit0", {31'd0, jif.joy_data}, 32'd0);
    drive(1'b1, 1'b1);
    chk("t2_latency", t_chg - t_pin, 5);
    cap[1] = jif.joy_data;
    drive(1'b1, 1'b0);
    edges(2, 24);
    chk("t2_stream", {8'd0, cap}, 32'hBFFFEE);
    chk("t2_done", done_cnt, 1);
    chk("t2_cnt_sat", {27'd0, bit_cnt}, 32'd24);
    drive(1'b1, 1'b1);
    chk("t2_edge25_data", {31'd0, jif.joy_data}, 32'd1);
    chk("t2_edge25_cnt", {27'd0, bit_cnt}, 32'd24);
    drive(1'b1, 1'b0);
    chk("t2_done_once", done_cnt, 1);

    // 3: inputs change after snapshot
    load_frame();
    edges(1, 4);
    j1 = 12'hFFF;
    edges(5, 24);
    chk("t3_stream", {8'd0, cap}, 32'hBFFFEE);
    chk("t3_done", done_cnt, 2);

    // 4: load mid-frame, clk high during load release
    j1 = 12'h0A5;
    j2 = 12'h3C0;
    load_frame();
    edges(1, 10);
    drive(1'b0, 1'b0);
    chk("t4_cnt", {27'd0, bit_cnt}, 32'd0);
    chk("t4_data", {31'd0, jif.joy_data}, 32'd0);
    chk("t4_no_done", done_cnt, 2);
    drive(1'b0, 1'b1);
    drive(1'b1, 1'b1);
    chk("t4_highclk_cnt", {27'd0, bit_cnt}, 32'd0);
    cap = '1;
    cap[0] = jif.joy_data;
    drive(1'b1, 1'b0);
    edges(1, 24);
    chk("t4_stream", {8'd0, cap}, 32'hC3FF5A);
    chk("t4_done", done_cnt, 3);

    // 4b: load and clk edge together -> load wins
    load_frame();
    edges(1, 3);
    drive(1'b0, 1'b1);
    chk("t4b_cnt", {27'd0, bit_cnt}, 32'd0);
    chk("t4b_data", {31'd0, jif.joy_data}, 32'd0);
    drive(1'b0, 1'b0);
    drive(1'b1, 1'b1);
    chk("t4b_rel_cnt", {27'd0, bit_cnt}, 32'd0);
    cap = '1;
    cap[0] = jif.joy_data;
    drive(1'b1, 1'b0);
    edges(1, 24);
    chk("t4b_stream", {8'd0, cap}, 32'hC3FF5A);
    chk("t4b_done", done_cnt, 4);

    // 5: glitch filter
    j1 = 12'h011;
    j2 = 12'h400;
    load_frame();
    edges(1, 2);
    clk_pulse(1);
    chk("t5_glitch", {27'd0, bit_cnt}, 32'd2);
    clk_pulse(3);
    chk("t5_pulse", {27'd0, bit_cnt}, 32'd3);
    cap[3] = jif.joy_data;
    edges(4, 24);
    chk("t5_stream", {8'd0, cap}, 32'hBFFFEE);
    chk("t5_done", done_cnt, 5);

    // 6: reset mid-frame
    load_frame();
    edges(1, 15);
    do_reset();
    chk("t6_data", {31'd0, jif.joy_data}, 32'd1);
    chk("t6_cnt", {27'd0, bit_cnt}, 32'd0);
    chk("t6_busy", {31'd0, busy}, 32'd0);
    edges(1, 2);
    chk("t6_noload_cnt", {27'd0, bit_cnt}, 32'd0);
    load_frame();
    edges(1, 24);
    chk("t6_stream", {8'd0, cap}, 32'hBFFFEE);
    chk("t6_done", done_cnt, 6);

    repeat (4) @(posedge clk_sys);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
